// File: rtl/data_memory_controller_if.sv
// Bundles the request, response and memory-port signals of the data memory
// controller. The slave modport is the controller's view; the master modport
// is the view of the surrounding MEM stage and memory together.
// Request handshake: a request transfers on the rising clock edge where
// req_valid_in and req_ready_out are both 1; the requester holds its fields
// stable while req_valid_in is 1 and req_ready_out is 0.
interface data_memory_controller_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_write_in;
    logic [31:0] req_addr_in;
    logic [1:0]  req_size_in;
    logic        req_signed_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic        resp_error_out;
    logic [31:0] resp_rdata_out;
    logic [1:0]  resp_offset_out;
    logic [1:0]  resp_size_out;
    logic        resp_signed_out;
    logic        mem_en_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;
    logic        mem_ack_in;

    modport slave (
        input  req_valid_in, req_write_in, req_addr_in, req_size_in,
               req_signed_in, req_wdata_in, mem_rdata_in, mem_ack_in,
        output req_ready_out, resp_valid_out, resp_error_out, resp_rdata_out,
               resp_offset_out, resp_size_out, resp_signed_out,
               mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
    );

    modport master (
        output req_valid_in, req_write_in, req_addr_in, req_size_in,
               req_signed_in, req_wdata_in, mem_rdata_in, mem_ack_in,
        input  req_ready_out, resp_valid_out, resp_error_out, resp_rdata_out,
               resp_offset_out, resp_size_out, resp_signed_out,
               mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
    );
endinterface

// File: rtl/data_memory_controller.sv
// Data memory controller: accepts one load/store at a time, drives a
// word-addressed ack-handshaked memory port, turns sub-word stores into
// read-modify-write, rejects misaligned/invalid requests without touching
// memory, and aborts a memory phase that waits too long for an ack.
module data_memory_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    data_memory_controller_if.slave  bus,
    output logic [2:0]               state_out
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_RMW_WR = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    // Counter value seen in the last cycle a phase may still wait for an ack.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      addr_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [31:0]      wdata_q;   // store data, later replaced by the RMW merge
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [31:0]      merge;
    logic             req_bad;
    logic             timeout_hit;

    // Reject invalid size, odd halfword and unaligned word addresses.
    always_comb begin
        req_bad = (bus.req_size_in == 2'b10) ||
                  (bus.req_size_in == 2'b01 && bus.req_addr_in[0]) ||
                  (bus.req_size_in == 2'b11 && bus.req_addr_in[1:0] != 2'b00);
    end

    // Replace one byte or halfword lane of the word read during RMW.
    always_comb begin
        merge = bus.mem_rdata_in;
        if (size_q == 2'b01) begin
            if (addr_q[1]) merge[31:16] = wdata_q[15:0];
            else           merge[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    merge[7:0]   = wdata_q[7:0];
                2'd1:    merge[15:8]  = wdata_q[7:0];
                2'd2:    merge[23:16] = wdata_q[7:0];
                default: merge[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // A phase gives up once it has waited TIMEOUT_CYCLES cycles without ack.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);
    end

    // Main FSM: accept, run the memory phases, then pulse the response.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid_in) begin
                        addr_q   <= bus.req_addr_in;
                        size_q   <= bus.req_size_in;
                        signed_q <= bus.req_signed_in;
                        wdata_q  <= bus.req_wdata_in;
                        rdata_q  <= '0;
                        wait_cnt <= '0;
                        err_q    <= req_bad;
                        if (req_bad)                       state <= ST_RESP;
                        else if (!bus.req_write_in)        state <= ST_READ;
                        else if (bus.req_size_in == 2'b11) state <= ST_WRITE;
                        else                               state <= ST_RMW_RD;
                    end
                end
                ST_READ, ST_RMW_RD, ST_RMW_WR, ST_WRITE: begin
                    if (bus.mem_ack_in) begin
                        wait_cnt <= '0;
                        if (state == ST_READ) begin
                            rdata_q <= bus.mem_rdata_in;
                            state   <= ST_RESP;
                        end else if (state == ST_RMW_RD) begin
                            wdata_q <= merge;
                            state   <= ST_RMW_WR;
                        end else begin
                            state <= ST_RESP;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode directly from the state and latched request fields.
    always_comb begin
        bus.req_ready_out   = (state == ST_IDLE);
        bus.resp_valid_out  = (state == ST_RESP);
        bus.resp_error_out  = (state == ST_RESP) && err_q;
        bus.resp_rdata_out  = rdata_q;
        bus.resp_offset_out = addr_q[1:0];
        bus.resp_size_out   = size_q;
        bus.resp_signed_out = signed_q;
        bus.mem_en_out      = (state == ST_READ) || (state == ST_RMW_RD) ||
                              (state == ST_RMW_WR) || (state == ST_WRITE);
        bus.mem_we_out      = (state == ST_RMW_WR) || (state == ST_WRITE);
        bus.mem_addr_out    = {addr_q[31:2], 2'b00};
        bus.mem_wdata_out   = wdata_q;
        state_out           = state;
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: a vector table of requests with the
// expected memory traffic, latency and response, a response scoreboard, and
// hand-written reset sequences.
module tb_data_memory_controller;

    localparam int RW = 38;  // {error, rdata, offset, size, signed}

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] mem_word;
        int          waits;      // wait cycles before each ack
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;  // word written on the final write phase
        int          exp_lat;    // accept cycle to resp_valid_out
        int          exp_en;     // cycles with mem_en_out high
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    dbg_state;
    logic [RW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    vec_t          vecs[12];

    data_memory_controller_if bus();

    data_memory_controller #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clock_in  (clk),
        .reset_in  (rst),
        .bus       (bus.slave),
        .state_out (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                input logic sg, input logic [31:0] wd, input logic [31:0] mw,
                                input int wt, input logic er, input logic [31:0] rd,
                                input logic [31:0] ewd, input int lat, input int en);
        vec_t v;
        v.write = w; v.addr = a; v.size = sz; v.sgn = sg; v.wdata = wd;
        v.mem_word = mw; v.waits = wt; v.exp_err = er; v.exp_rdata = rd;
        v.exp_wdata = ewd; v.exp_lat = lat; v.exp_en = en;
        return v;
    endfunction

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got a response pulse, required none at %0t", $time);
            end else begin
                chk("resp_fields",
                    {bus.resp_error_out, bus.resp_rdata_out, bus.resp_offset_out,
                     bus.resp_size_out, bus.resp_signed_out},
                    exp_q.pop_front());
            end
        end
    end

    task automatic drive_req(input vec_t v);
        bus.req_write_in  = v.write;
        bus.req_addr_in   = v.addr;
        bus.req_size_in   = v.size;
        bus.req_signed_in = v.sgn;
        bus.req_wdata_in  = v.wdata;
        bus.mem_rdata_in  = v.mem_word;
        bus.req_valid_in  = 1'b1;
    endtask

    // Issue one request, play the memory and check traffic and latency.
    task automatic run_txn(input vec_t v);
        int  cyc, w, phase, en_cnt;
        bit  got;
        logic exp_we;
        drive_req(v);
        exp_q.push_back({v.exp_err, v.exp_rdata, v.addr[1:0], v.size, v.sgn});
        @(negedge clk);
        chk("accept_ready", bus.req_ready_out, 1);
        @(posedge clk); #1;
        bus.req_valid_in  = 1'b0;
        bus.req_addr_in   = $urandom;
        bus.req_wdata_in  = $urandom;
        bus.req_size_in   = 2'($urandom_range(0, 3));
        bus.req_signed_in = 1'($urandom_range(0, 1));
        cyc = 1; w = 0; phase = 0; en_cnt = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (bus.resp_valid_out) begin
                got = 1;
                chk("latency", cyc, v.exp_lat);
            end else begin
                chk("busy_ready", bus.req_ready_out, 0);
                if (bus.mem_en_out) begin
                    en_cnt++;
                    exp_we = !v.write ? 1'b0 : (v.size == 2'b11 ? 1'b1 : (phase != 0));
                    chk("mem_addr", bus.mem_addr_out, {v.addr[31:2], 2'b00});
                    chk("mem_we", bus.mem_we_out, exp_we);
                    if (w == v.waits) begin
                        bus.mem_ack_in = 1'b1;
                        if (bus.mem_we_out) chk("mem_wdata", bus.mem_wdata_out, v.exp_wdata);
                        w = 0;
                        phase++;
                    end else begin
                        w++;
                    end
                end
            end
            @(posedge clk); #1;
            bus.mem_ack_in = 1'b0;
            cyc++;
        end
        if (!got) chk("resp_arrival", 0, 1);
        chk("en_cycles", en_cnt, v.exp_en);
        @(negedge clk);
        chk("idle_ready", bus.req_ready_out, 1);
        chk("fields_hold", {bus.resp_valid_out, bus.resp_offset_out, bus.resp_size_out,
                            bus.resp_signed_out}, {1'b0, v.addr[1:0], v.size, v.sgn});
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ctrl"}, {bus.req_ready_out, bus.resp_valid_out, bus.resp_error_out,
                              bus.mem_en_out, bus.mem_we_out, bus.resp_offset_out,
                              bus.resp_size_out, bus.resp_signed_out}, 10'h200);
        chk({name, "_rdata"}, bus.resp_rdata_out, 0);
        chk({name, "_addr"}, bus.mem_addr_out, 0);
        chk({name, "_wdata"}, bus.mem_wdata_out, 0);
    endtask

    initial begin
        vecs[0]  = mk(0, 32'h100, 2'b11, 0, 32'h0,        32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 32'h0,        2, 1);
        vecs[1]  = mk(1, 32'h203, 2'b00, 0, 32'h000000AB, 32'h11223344, 2,  0, 32'h0,        32'hAB223344, 7, 6);
        vecs[2]  = mk(1, 32'h302, 2'b01, 0, 32'h0000CAFE, 32'h55667788, 0,  0, 32'h0,        32'hCAFE7788, 3, 2);
        vecs[3]  = mk(0, 32'h401, 2'b01, 1, 32'h0,        32'h12345678, 0,  1, 32'h0,        32'h0,        1, 0);
        vecs[4]  = mk(0, 32'h402, 2'b11, 0, 32'h0,        32'h12345678, 0,  1, 32'h0,        32'h0,        1, 0);
        vecs[5]  = mk(1, 32'h500, 2'b10, 0, 32'h9999,     32'h12345678, 0,  1, 32'h0,        32'h0,        1, 0);
        vecs[6]  = mk(1, 32'h600, 2'b11, 0, 32'h12345678, 32'hFFFFFFFF, 1,  0, 32'h0,        32'h12345678, 3, 2);
        vecs[7]  = mk(1, 32'h700, 2'b00, 0, 32'hFFFFFF5A, 32'h00000000, 0,  0, 32'h0,        32'h0000005A, 3, 2);
        vecs[8]  = mk(0, 32'h805, 2'b00, 1, 32'h0,        32'hA1B2C3D4, 1,  0, 32'hA1B2C3D4, 32'h0,        3, 2);
        vecs[9]  = mk(1, 32'h901, 2'b00, 1, 32'h00000077, 32'hFFFFFFFF, 0,  0, 32'h0,        32'hFFFF77FF, 3, 2);
        vecs[10] = mk(0, 32'hA00, 2'b11, 0, 32'h0,        32'hCCCCCCCC, 99, 1, 32'h0,        32'h0,        5, 4);
        vecs[11] = mk(0, 32'hB00, 2'b11, 0, 32'h0,        32'h0BADF00D, 3,  0, 32'h0BADF00D, 32'h0,        5, 4);

        bus.req_valid_in = 1'b0; bus.req_write_in = 1'b0; bus.req_addr_in = '0;
        bus.req_size_in = '0; bus.req_signed_in = 1'b0; bus.req_wdata_in = '0;
        bus.mem_rdata_in = '0; bus.mem_ack_in = 1'b0;

        // Clock/reset: hold reset, check reset values, release after a posedge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_init");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_txn(vecs[i]);

        // Reset in the middle of an RMW read phase abandons it silently.
        drive_req(vecs[1]);
        @(posedge clk); #1;
        bus.req_valid_in = 1'b0;
        @(negedge clk);
        chk("mid_rmw_en", {bus.mem_en_out, bus.mem_we_out}, 2'b10);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("reset_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(vecs[2]);
        run_txn(vecs[0]);

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- Sequences every data-memory access from the MEM stage: accepts one load/store request at a time and drives a word-addressed, ack-handshaked memory port.
- Sub-word stores become read-modify-write (RMW) sequences.
- Misaligned and invalid-size requests are rejected with no memory access.
- Load responses carry the raw 32-bit word plus the latched size/offset/signed fields, which drive the downstream load extractor.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for mem_ack_in per memory phase before aborting with error; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock_in  in  1  sole clock, rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- req_valid_in  in  1  request present.
- req_ready_out  out  1  controller can accept a request.
- req_write_in  in  1  1=store, 0=load.
- req_addr_in  in  32  byte address.
- req_size_in  in  2  11=word, 01=half, 00=byte, 10=invalid.
- req_signed_in  in  1  extension control, latched and forwarded unchanged.
- req_wdata_in  in  32  store data, right-justified.
- resp_valid_out  out  1  one-cycle completion pulse for loads and stores.
- resp_error_out  out  1  qualifies resp_valid_out: misaligned, invalid size, or timeout.
- resp_rdata_out  out  32  raw memory word (loads); 0 for stores and errors.
- resp_offset_out  out  2  latched req_addr_in[1:0].
- resp_size_out  out  2  latched req_size_in.
- resp_signed_out  out  1  latched req_signed_in.
- mem_en_out  out  1  memory access strobe.
- mem_we_out  out  1  memory write enable.
- mem_addr_out  out  32  {req_addr[31:2], 2'b00}.
- mem_wdata_out  out  32  write word.
- mem_rdata_in  in  32  read word, valid with mem_ack_in.
- mem_ack_in  in  1  completes the current memory phase.

Behaviour:
- Reset (asynchronous): state=IDLE, every output 0 except req_ready_out=1, timeout counter 0, latched request fields 0. Reset mid-access abandons the access; no response is issued.
- States:
  - IDLE: req_ready_out=1; handshake is req_valid_in & req_ready_out; latch addr, size, signed, write, wdata on the handshake.
  - READ: mem_en_out=1, mem_we_out=0.
  - RMW_RD: mem_en_out=1, mem_we_out=0.
  - RMW_WR: mem_en_out=1, mem_we_out=1.
  - WRITE: mem_en_out=1, mem_we_out=1.
  - RESP: resp_valid_out=1 for exactly one cycle, then IDLE.
- req_ready_out is 0 in every state other than IDLE.
- Transitions from IDLE on handshake:
  - Alignment check first: size=10, half with offset[0]=1, or word with offset!=00 -> RESP with error. No mem_en is ever asserted for these.
  - Load -> READ.
  - Word store -> WRITE.
  - Half/byte store -> RMW_RD.
- READ: on mem_ack_in, capture mem_rdata_in into resp_rdata_out, go to RESP.
- RMW_RD: on ack, form merge = mem_rdata_in with one lane replaced, go to RMW_WR with mem_wdata_out=merge.
  - Byte at offset k replaces bits [8k+7:8k] with wdata[7:0].
  - Half at offset 0 replaces [15:0]; at offset 2 replaces [31:16]; source is wdata[15:0].
- RMW_WR and WRITE: on ack -> RESP. WRITE drives mem_wdata_out = wdata unchanged.
- mem_en_out, mem_we_out, mem_addr_out and mem_wdata_out are held stable from phase start until the ack cycle inclusive. mem_en_out drops in the cycle after the ack.
- mem_ack_in is ignored in IDLE and RESP.
- Latency with zero-wait memory (ack in the first enable cycle), counted from the accept cycle C:
  - load or word store: resp_valid_out at C+2.
  - sub-word store: resp_valid_out at C+3.
  - error: resp_valid_out at C+1.
- Next accept is possible at RESP+1.
- Timeout: counter clears on entry to each memory phase and increments every cycle without ack. When it reaches TIMEOUT_CYCLES (if nonzero): drop mem_en_out, go to RESP with resp_error_out=1 and resp_rdata_out=0. An ack arriving in the same cycle wins over the timeout.
- The response fields (offset, size, signed) stay valid until the next accept.
- No response backpressure: the consumer must take the resp_valid_out pulse.

Test Plan:
- Load word, addr 0x100, ack on first enable cycle, mem_rdata_in=0xDEADBEEF -> mem_addr_out=0x100, we=0; resp_valid_out at C+2 with rdata=0xDEADBEEF, error=0.
- Byte store, addr 0x203, wdata 0x000000AB, memory word 0x11223344, acks after 2 wait cycles each -> read phase then write phase with mem_wdata_out=0xAB223344; single resp pulse; req_ready_out low throughout.
- Half store, addr 0x302, wdata 0x0000CAFE, memory word 0x55667788 -> mem_wdata_out=0xCAFE7788.
- Misaligned requests (half at 0x401, word at 0x402) and size=10 -> resp_valid_out and resp_error_out at C+1; mem_en_out never asserted.
- TIMEOUT_CYCLES=4, load with ack never asserted -> mem_en_out drops, resp_error_out=1; then load with ack exactly on the 4th wait cycle -> success with no error.
- reset_in asserted mid-RMW_RD -> all outputs 0 immediately, req_ready_out=1, no resp pulse; the next request completes normally.
